sd_cmd_tx: RTL and testbench

SPI-mode SD command transmitter: serialises a 48-bit SD command frame (start bit, transmission bit, 6-bit index, 32-bit argument, CRC7, end bit) MSB-first onto the card's DI line, one bit per `clk`. It is the command-side counterpart of the response receiver. It publishes the index of the last issued command so the receiver can select the correct response length (R1 vs. R7 for CMD8). CRC7 is generated on the fly, so callers supply only index and argument.

---
 rtl/sd_pkg.sv | 30 +++
 rtl/sd_crc7.sv | 31 +++
 rtl/sd_cmd_tx.sv | 145 ++++++++++++++
 tb/tb_sd_cmd_tx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared SD SPI-mode definitions: FSM states, frame constants, command indices
// and the serial CRC7 update step used by the command and data paths.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_FRAME,
        ST_CRC,
        ST_END
    } sd_state_e;

    localparam int          SD_FRAME_BITS = 48;
    localparam logic [6:0]  SD_CRC7_POLY  = 7'h09;

    localparam logic [5:0]  CMD0   = 6'd0;
    localparam logic [5:0]  CMD8   = 6'd8;
    localparam logic [5:0]  CMD17  = 6'd17;
    localparam logic [5:0]  CMD24  = 6'd24;
    localparam logic [5:0]  CMD55  = 6'd55;
    localparam logic [5:0]  ACMD41 = 6'd41;

    // One shift of x^7+x^3+1 with the incoming bit folded into the feedback.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator. A clear and an enable in the same cycle restart the
// CRC from zero and absorb bit_in, so the first bit of a frame is never lost.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] r_crc;
    logic [6:0] w_base;

    assign w_base = clr ? 7'h00 : r_crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= 7'h00;
        end else if (en) begin
            r_crc <= crc7_step(w_base, bit_in);
        end else if (clr) begin
            r_crc <= 7'h00;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/sd_cmd_tx.sv
// SPI-mode SD command transmitter: sends {01, index, arg, CRC7, 1} MSB-first on
// DI after PRE_BITS idle-high cycles, generating the CRC7 as bits go out.
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int PRE_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  cmd,
    input  logic [31:0] arg,
    output logic        DI,
    output logic        busy,
    output logic        done,
    output logic [5:0]  cmd_sent
);

    localparam logic [5:0] PRE_LOAD = (PRE_BITS > 0) ? 6'(PRE_BITS - 1) : 6'd0;

    sd_state_e   r_state, w_state_nx;
    logic [39:0] r_sr, w_sr_nx;
    logic [5:0]  r_cnt, w_cnt_nx;
    logic        r_di, w_di_nx;
    logic        r_done, w_done_nx;
    logic [5:0]  r_cmd_sent, w_cmd_sent_nx;

    logic        w_crc_clr;
    logic        w_crc_en;
    logic        w_crc_bit;
    logic [6:0]  w_crc;
    logic [39:0] w_frame;
    logic [2:0]  w_crc_idx;

    assign w_frame   = {2'b01, cmd, arg};
    assign w_crc_idx = r_cnt[2:0] - 3'd1;

    sd_crc7 u_crc7 (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_crc_clr),
        .en     (w_crc_en),
        .bit_in (w_crc_bit),
        .crc    (w_crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sr       <= '0;
            r_cnt      <= '0;
            r_di       <= 1'b1;
            r_done     <= 1'b0;
            r_cmd_sent <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_sr       <= w_sr_nx;
            r_cnt      <= w_cnt_nx;
            r_di       <= w_di_nx;
            r_done     <= w_done_nx;
            r_cmd_sent <= w_cmd_sent_nx;
        end
    end

    // The state names what DI shows after the edge; r_cnt counts bits still to go.
    always_comb begin
        w_state_nx    = r_state;
        w_sr_nx       = r_sr;
        w_cnt_nx      = r_cnt;
        w_di_nx       = 1'b1;
        w_done_nx     = 1'b0;
        w_cmd_sent_nx = r_cmd_sent;
        w_crc_clr     = 1'b0;
        w_crc_en      = 1'b0;
        w_crc_bit     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_cmd_sent_nx = cmd;
                    w_crc_clr     = 1'b1;
                    if (PRE_BITS == 0) begin
                        w_state_nx = ST_FRAME;
                        w_di_nx    = w_frame[39];
                        w_sr_nx    = {w_frame[38:0], 1'b0};
                        w_crc_en   = 1'b1;
                        w_crc_bit  = w_frame[39];
                        w_cnt_nx   = 6'd39;
                    end else begin
                        w_state_nx = ST_PRE;
                        w_sr_nx    = w_frame;
                        w_cnt_nx   = PRE_LOAD;
                    end
                end
            end
            ST_PRE: begin
                if (r_cnt == 6'd0) begin
                    w_state_nx = ST_FRAME;
                    w_di_nx    = r_sr[39];
                    w_sr_nx    = {r_sr[38:0], 1'b0};
                    w_crc_en   = 1'b1;
                    w_crc_bit  = r_sr[39];
                    w_cnt_nx   = 6'd39;
                end else begin
                    w_cnt_nx = r_cnt - 6'd1;
                end
            end
            ST_FRAME: begin
                if (r_cnt == 6'd0) begin
                    // CRC is complete here and stays frozen while it is shifted out.
                    w_state_nx = ST_CRC;
                    w_di_nx    = w_crc[6];
                    w_cnt_nx   = 6'd6;
                end else begin
                    w_di_nx   = r_sr[39];
                    w_sr_nx   = {r_sr[38:0], 1'b0};
                    w_crc_en  = 1'b1;
                    w_crc_bit = r_sr[39];
                    w_cnt_nx  = r_cnt - 6'd1;
                end
            end
            ST_CRC: begin
                if (r_cnt == 6'd0) begin
                    w_state_nx = ST_END;
                end else begin
                    w_di_nx  = w_crc[w_crc_idx];
                    w_cnt_nx = r_cnt - 6'd1;
                end
            end
            ST_END: begin
                w_state_nx = ST_IDLE;
                w_done_nx  = 1'b1;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign DI       = r_di;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign cmd_sent = r_cmd_sent;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx: one instance with PRE_BITS=8, one with PRE_BITS=0.
module tb_sd_cmd_tx;
    import sd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start0;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        di, busy, done;
    logic [5:0]  cmd_sent;
    logic        di0, busy0, done0;
    logic [5:0]  cmd_sent0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sd_cmd_tx #(.PRE_BITS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .arg(arg),
        .DI(di), .busy(busy), .done(done), .cmd_sent(cmd_sent)
    );

    sd_cmd_tx #(.PRE_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .cmd(cmd), .arg(arg),
        .DI(di0), .busy(busy0), .done(done0), .cmd_sent(cmd_sent0)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one command on the PRE_BITS=8 instance; optionally pulses start
    // (with CMD0) at frame-relative cycle pulse_at to prove it is ignored.
    task automatic run_frame(input string tag, input logic [5:0] c, input logic [31:0] a,
                             input logic [47:0] frame, input int pulse_at);
        logic [55:0] cap;
        int          dones;
        logic        busy_ok;
        @(negedge clk);
        start = 1'b1; cmd = c; arg = a;
        @(posedge clk);
        cap = '0; dones = 0; busy_ok = 1'b1;
        for (int i = 0; i < 56; i++) begin
            @(negedge clk);
            start = (i == pulse_at);
            cmd   = (i == pulse_at) ? CMD0 : 6'h3F;
            arg   = 32'hFFFF_FFFF;
            cap   = {cap[54:0], di};
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) dones++;
        end
        start = 1'b0;
        @(negedge clk);
        if (done === 1'b1) dones++;
        chk({tag, "_done"}, 128'(done), 128'(1'b1));
        chk({tag, "_busy_end"}, 128'(busy), 128'(1'b0));
        chk({tag, "_di_idle"}, 128'(di), 128'(1'b1));
        @(negedge clk);
        chk({tag, "_done_clr"}, 128'(done), 128'(1'b0));
        chk({tag, "_done_count"}, 128'(dones), 128'(1));
        chk({tag, "_bits"}, 128'(cap), 128'({8'hFF, frame}));
        chk({tag, "_busy_hold"}, 128'(busy_ok), 128'(1'b1));
        chk({tag, "_cmd_sent"}, 128'(cmd_sent), 128'(c));
    endtask

    initial begin
        logic [127:0] bcap;
        logic [47:0]  cap0;

        rst = 1'b1; start = 1'b0; start0 = 1'b0; cmd = '0; arg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_di", 128'(di), 128'(1'b1));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_cmd_sent", 128'(cmd_sent), 128'(6'd0));

        run_frame("cmd0", CMD0, 32'h0, 48'h40_00_00_00_00_95, -1);
        run_frame("cmd8", CMD8, 32'h0000_01AA, 48'h48_00_00_01_AA_87, -1);

        // CMD55 then ACMD41 with start held: 8 pre, frame, done cycle, 8 pre, frame.
        @(negedge clk);
        start = 1'b1; cmd = CMD55; arg = 32'h0;
        @(posedge clk);
        bcap = '0;
        for (int i = 0; i < 113; i++) begin
            @(negedge clk);
            if (i == 0) begin cmd = ACMD41; arg = 32'h4000_0000; end
            bcap = {bcap[126:0], di};
            if (i == 55) chk("b2b_cmd_sent1", 128'(cmd_sent), 128'(CMD55));
            if (i == 56) begin
                chk("b2b_done1", 128'(done), 128'(1'b1));
                chk("b2b_busy_gap", 128'(busy), 128'(1'b0));
            end
            if (i == 57) begin
                chk("b2b_cmd_sent2", 128'(cmd_sent), 128'(ACMD41));
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_done2", 128'(done), 128'(1'b1));
        chk("b2b_bits", bcap,
            128'({8'hFF, 48'h77_00_00_00_00_65, 1'b1, 8'hFF, 48'h69_40_00_00_00_77}));

        run_frame("cmd17_pulse", CMD17, 32'h0, 48'h51_00_00_00_00_55, 28);

        // Abort CMD17 once frame bit 20 is on DI.
        @(negedge clk);
        start = 1'b1; cmd = CMD17; arg = 32'h0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (28) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_di", 128'(di), 128'(1'b1));
        chk("abort_busy", 128'(busy), 128'(1'b0));
        chk("abort_done", 128'(done), 128'(1'b0));
        chk("abort_cmd_sent", 128'(cmd_sent), 128'(6'd0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame("cmd17_after", CMD17, 32'h0, 48'h51_00_00_00_00_55, -1);

        // PRE_BITS=0 instance: start bit right after acceptance, done after 48 edges.
        @(negedge clk);
        start0 = 1'b1; cmd = CMD0; arg = 32'h0;
        @(posedge clk);
        cap0 = '0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (i == 0) chk("p0_first_bit", 128'(di0), 128'(1'b0));
            cap0 = {cap0[46:0], di0};
        end
        chk("p0_busy_end_bit", 128'(busy0), 128'(1'b1));
        @(negedge clk);
        chk("p0_done", 128'(done0), 128'(1'b1));
        chk("p0_busy", 128'(busy0), 128'(1'b0));
        chk("p0_bits", 128'(cap0), 128'(48'h40_00_00_00_00_95));
        chk("p0_cmd_sent", 128'(cmd_sent0), 128'(CMD0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
